pc_unit: RTL and testbench
==========================

# pc_unit

Program-counter stage driven directly by the microcoded control unit. It holds the instruction address, increments it, and drives it onto the data bus for fetch. It loads jump targets from the bus, gated by a branch condition evaluated against latched ALU N/Z flags. A small return-address stack supports call/return.

## Interface
Parameters:
- WIDTH, 8, PC and bus width in bits
- STACK_DEPTH, 4, return-stack entries (power of two, ≥2)

Ports:
- i_clk  input  1  system clock; all state changes on rising edge
- i_reset  input  1  synchronous, active-high reset
- i_ctrlLoadPC  input  1  load PC from i_bus if condition taken
- i_ctrlIncrPC  input  1  increment PC
- i_ctrlPCOe  input  1  request to drive PC onto bus
- i_ctrlAluOE  input  1  ALU result on bus this cycle; latch flags
- i_ctrlPush  input  1  push current PC onto return stack
- i_ctrlPop  input  1  pop return stack into PC
- i_aluFlagN  input  1  ALU negative flag
- i_aluFlagZ  input  1  ALU zero flag
- i_condition  input  3  branch condition field from instruction register
- i_bus  input  WIDTH  data bus value
- o_bus  output  WIDTH  current PC (always r_pc)
- o_busEn  output  1  bus drive enable, equals i_ctrlPCOe (combinational)
- o_pc  output  WIDTH  current PC, to RAM address path
- o_stackOverflow  output  1  sticky: push attempted while full
- o_stackUnderflow  output  1  sticky: pop attempted while empty

## Operation
- Reset: r_pc=0, stack pointer=0, stack entries=0, latched N=Z=0, both sticky errors=0.
- Flag latch: on an edge with i_ctrlAluOE=1, r_flagN/r_flagZ take i_aluFlagN/i_aluFlagZ. Condition evaluation always uses the flag values held before the edge.
- Conditions: 000 always, 001 Z, 010 !Z, 011 N, 100 !N, 101 N|Z, 110 !N&!Z, 111 never.
- PC next-state priority, highest first:
  - pop valid → top of stack
  - load & taken → i_bus
  - incr → r_pc+1, modulo 2^WIDTH (max wraps to 0)
  - otherwise hold
- Load not taken with incr=1 → increment. Load not taken with incr=0 → hold.
- Push stores r_pc before update, so push+load in one cycle is a call: old PC pushed, target loaded.
- Push when full: ignored, PC update proceeds, o_stackOverflow set.
- Pop when empty: ignored, falls through to lower priorities, o_stackUnderflow set.
- Push+pop same cycle: swap. PC←top, top←old r_pc, pointer unchanged. If the stack is empty, it behaves as push, and underflow is set.
- Sticky errors clear only on reset.

## Timing
- All registered updates take effect one edge after control assertion. o_pc/o_bus reflect the new value in the following cycle.
- o_busEn has zero-cycle latency (combinational from i_ctrlPCOe). o_bus has no combinational path from inputs.
- Reset asserted mid-sequence overrides every control input on that edge.
- Flag latch and branch on the same edge: the branch uses the old flags, and the new flags are visible next cycle.

## Structure
- Shared package edic_pkg:
  - cond_t enum (COND_ALWAYS … COND_NEVER)
  - default WIDTH constant
- Sub-module return_stack:
  - LIFO with push/pop/swap
  - full/empty outputs and top output
  - pointer width $clog2(STACK_DEPTH)+1
- pc_unit contains the flag latch, condition mux, PC register/priority mux and sticky error bits.

## Test plan
- Reset, then incr 3 cycles → o_pc 0,1,2,3. Preload 0xFF then incr → 0x00.
- Latch Z=1 via AluOE; load, cond=001, bus=0x40 → PC=0x40. Same with cond=010 and incr=1 → PC+1.
- AluOE with N=1 and load cond=011 on the same edge → not taken (old N=0). Repeat next cycle → taken.
- PC=0x10, push+load bus=0x80 → PC=0x80, stack top 0x10. Pop → PC=0x10.
- 5 pushes at depth 4 → fifth ignored, overflow=1. 5 pops → last pop with incr=1 increments, underflow=1. Both clear on reset.
- PC=0x22, top=0x55, push+pop → PC=0x55, top=0x22, depth unchanged. PCOe=1 → o_busEn=1 same cycle, o_bus=0x55.

Source files
------------

// File: rtl/edic_pkg.sv
// edic_pkg: definitions shared by the PC stage and its return stack.
//   cond_t        - 3-bit branch condition encoding from the instruction register
//   DEFAULT_WIDTH - default PC / data bus width
//   cond_taken()  - evaluates a condition against latched N/Z flags
package edic_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [2:0] {
      COND_ALWAYS = 3'b000,
      COND_Z      = 3'b001,
      COND_NZ     = 3'b010,
      COND_N      = 3'b011,
      COND_NN     = 3'b100,
      COND_N_OR_Z = 3'b101,
      COND_POS    = 3'b110,  // !N & !Z
      COND_NEVER  = 3'b111
   } cond_t;

   function automatic logic cond_taken(input cond_t c, input logic n, input logic z);
      case (c)
         COND_ALWAYS: cond_taken = 1'b1;
         COND_Z:      cond_taken = z;
         COND_NZ:     cond_taken = !z;
         COND_N:      cond_taken = n;
         COND_NN:     cond_taken = !n;
         COND_N_OR_Z: cond_taken = n | z;
         COND_POS:    cond_taken = !n & !z;
         default:     cond_taken = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/return_stack.sv
// return_stack: small LIFO of return addresses.
//   i_clk, i_reset     - clock, synchronous active-high reset
//   i_push, i_pop      - push i_data / pop; both together swap i_data with the top
//   i_data             - value to push (current PC)
//   o_top              - top entry (meaningless while o_empty)
//   o_full, o_empty    - occupancy flags
// Push while full is dropped. Pop while empty is dropped. Push+pop on an
// empty stack degenerates into a plain push.
module return_stack #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_top,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]                 sp_q;
   logic [DEPTH-1:0][WIDTH-1:0]   mem_q;
   logic [AW-1:0]                 top_idx;
   logic [AW-1:0]                 wr_idx;

   // DEPTH is a power of two, so the low pointer bits address the slot
   // directly; when full they wrap to 0 and top_idx wraps to DEPTH-1.
   assign wr_idx  = sp_q[AW-1:0];
   assign top_idx = wr_idx - AW'(1);
   assign o_empty = (sp_q == '0);
   assign o_full  = (sp_q == PW'(DEPTH));
   assign o_top   = mem_q[top_idx];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sp_q  <= '0;
         mem_q <= '0;
      end else if (i_push && i_pop && !o_empty) begin
         mem_q[top_idx] <= i_data;       // swap: pointer unchanged
      end else if (i_push && !o_full) begin
         mem_q[wr_idx] <= i_data;
         sp_q          <= sp_q + PW'(1);
      end else if (i_pop && !i_push && !o_empty) begin
         sp_q <= sp_q - PW'(1);
      end
   end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter stage driven by the microcoded control unit.
//   i_clk, i_reset        - clock, synchronous active-high reset
//   i_ctrlLoadPC          - load PC from i_bus when the condition is taken
//   i_ctrlIncrPC          - increment PC
//   i_ctrlPCOe            - drive PC onto the bus (o_busEn follows combinationally)
//   i_ctrlAluOE           - latch ALU N/Z flags on this edge
//   i_ctrlPush/i_ctrlPop  - return-stack push / pop (both = swap)
//   i_aluFlagN/Z          - ALU flags
//   i_condition           - branch condition field
//   i_bus                 - jump target source
//   o_bus, o_pc           - registered PC
//   o_busEn               - bus drive enable
//   o_stackOverflow/Underflow - sticky stack error flags, cleared by reset
module pc_unit
   import edic_pkg::*;
#(
   parameter int WIDTH       = DEFAULT_WIDTH,
   parameter int STACK_DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_ctrlLoadPC,
   input  logic             i_ctrlIncrPC,
   input  logic             i_ctrlPCOe,
   input  logic             i_ctrlAluOE,
   input  logic             i_ctrlPush,
   input  logic             i_ctrlPop,
   input  logic             i_aluFlagN,
   input  logic             i_aluFlagZ,
   input  logic [2:0]       i_condition,
   input  logic [WIDTH-1:0] i_bus,
   output logic [WIDTH-1:0] o_bus,
   output logic             o_busEn,
   output logic [WIDTH-1:0] o_pc,
   output logic             o_stackOverflow,
   output logic             o_stackUnderflow
);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic             flag_n_q, flag_z_q;
   logic             ovf_q, unf_q;
   logic [WIDTH-1:0] stk_top;
   logic             stk_full, stk_empty;
   logic             pop_valid, taken;

   return_stack #(.WIDTH(WIDTH), .DEPTH(STACK_DEPTH)) u_stack (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (i_ctrlPush),
      .i_pop   (i_ctrlPop),
      .i_data  (pc_q),
      .o_top   (stk_top),
      .o_full  (stk_full),
      .o_empty (stk_empty)
   );

   // Condition sees the flags held before this edge, even if AluOE is
   // latching new ones on the same edge.
   assign taken     = cond_taken(cond_t'(i_condition), flag_n_q, flag_z_q);
   assign pop_valid = i_ctrlPop && !stk_empty;

   always_comb begin
      pc_d = pc_q;
      if (pop_valid)                   pc_d = stk_top;
      else if (i_ctrlLoadPC && taken)  pc_d = i_bus;
      else if (i_ctrlIncrPC)           pc_d = pc_q + WIDTH'(1);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         pc_q     <= '0;
         flag_n_q <= 1'b0;
         flag_z_q <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         pc_q <= pc_d;
         if (i_ctrlAluOE) begin
            flag_n_q <= i_aluFlagN;
            flag_z_q <= i_aluFlagZ;
         end
         // push+pop on a full stack is a swap, not an overflow
         if (i_ctrlPush && !i_ctrlPop && stk_full) ovf_q <= 1'b1;
         if (i_ctrlPop && stk_empty)                unf_q <= 1'b1;
      end
   end

   assign o_pc             = pc_q;
   assign o_bus            = pc_q;
   assign o_busEn          = i_ctrlPCOe;
   assign o_stackOverflow  = ovf_q;
   assign o_stackUnderflow = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst, ld, inc, pcoe, aluoe, push, pop, fn, fz;
   logic [2:0]   cond;
   logic [W-1:0] bus_i;
   logic [W-1:0] bus_o, pc;
   logic         bus_en, ovf, unf;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   pc_unit #(.WIDTH(W), .STACK_DEPTH(4)) dut (
      .i_clk            (clk),
      .i_reset          (rst),
      .i_ctrlLoadPC     (ld),
      .i_ctrlIncrPC     (inc),
      .i_ctrlPCOe       (pcoe),
      .i_ctrlAluOE      (aluoe),
      .i_ctrlPush       (push),
      .i_ctrlPop        (pop),
      .i_aluFlagN       (fn),
      .i_aluFlagZ       (fz),
      .i_condition      (cond),
      .i_bus            (bus_i),
      .o_bus            (bus_o),
      .o_busEn          (bus_en),
      .o_pc             (pc),
      .o_stackOverflow  (ovf),
      .o_stackUnderflow (unf)
   );

   typedef struct {
      logic         rst, ld, inc, aluoe, push, pop, n, z;
      logic [2:0]   cond;
      logic [W-1:0] bus;
      logic [W-1:0] exp_pc;
      logic         exp_ovf, exp_unf;
   } vec_t;

   typedef struct {
      int           idx;
      logic [W-1:0] pc;
      logic         ovf, unf;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   function automatic vec_t mk(logic r, logic l, logic i, logic a, logic pu, logic po,
                               logic n, logic z, logic [2:0] c, logic [W-1:0] b,
                               logic [W-1:0] epc, logic eo, logic eu);
      vec_t v;
      v.rst = r; v.ld = l; v.inc = i; v.aluoe = a; v.push = pu; v.pop = po;
      v.n = n; v.z = z; v.cond = c; v.bus = b;
      v.exp_pc = epc; v.exp_ovf = eo; v.exp_unf = eu;
      return v;
   endfunction

   task automatic check(string name, int idx, logic [W-1:0] act, logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic apply(vec_t v, int idx);
      exp_t e;
      @(negedge clk);
      rst = v.rst; ld = v.ld; inc = v.inc; aluoe = v.aluoe; push = v.push; pop = v.pop;
      fn = v.n; fz = v.z; cond = v.cond; bus_i = v.bus;
      e.idx = idx; e.pc = v.exp_pc; e.ovf = v.exp_ovf; e.unf = v.exp_unf;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++; fails++;
         $display("FAIL scoreboard empty at vec %0d", idx);
      end else begin
         e = sb.pop_front();
         check("pc",  e.idx, pc, e.pc);
         check("bus", e.idx, bus_o, e.pc);
         check("ovf", e.idx, W'(ovf), W'(e.ovf));
         check("unf", e.idx, W'(unf), W'(e.unf));
      end
   endtask

   initial begin
      rst = 1; ld = 0; inc = 0; pcoe = 0; aluoe = 0; push = 0; pop = 0;
      fn = 0; fz = 0; cond = 0; bus_i = 0;

      //            rst ld inc alu psh pop n  z  cond    bus    pc     ov uf
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 8'h00, 8'h00, 0, 0)); // 0 reset
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 3'b000, 8'h00, 8'h01, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 3'b000, 8'h00, 8'h02, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 3'b000, 8'h00, 8'h03, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3'b000, 8'hFF, 8'hFF, 0, 0)); // preload FF
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 3'b000, 8'h00, 8'h00, 0, 0)); // 5 wrap
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 3'b000, 8'h00, 8'h00, 0, 0)); // latch Z=1
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3'b001, 8'h40, 8'h40, 0, 0)); // Z taken
      vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 3'b010, 8'h99, 8'h41, 0, 0)); // !Z not taken, incr
      vecs.push_back(mk(0, 1, 0, 1, 0, 0, 1, 0, 3'b011, 8'h70, 8'h41, 0, 0)); // N old=0
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3'b011, 8'h70, 8'h70, 0, 0)); // 10 N taken
      vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 3'b111, 8'h12, 8'h71, 0, 0)); // never
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3'b100, 8'h12, 8'h71, 0, 0)); // !N not taken, hold
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3'b101, 8'h10, 8'h10, 0, 0)); // N|Z
      vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 3'b000, 8'h80, 8'h80, 0, 0)); // call
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 3'b000, 8'h00, 8'h10, 0, 0)); // 15 return
      vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 3'b000, 8'h00, 8'h11, 0, 0)); // push 10
      vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 3'b000, 8'h00, 8'h12, 0, 0)); // push 11
      vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 3'b000, 8'h00, 8'h13, 0, 0)); // push 12
      vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 3'b000, 8'h00, 8'h14, 0, 0)); // push 13 (full)
      vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 3'b000, 8'h00, 8'h15, 1, 0)); // 20 overflow
      vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 3'b000, 8'h00, 8'h13, 1, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 3'b000, 8'h00, 8'h12, 1, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 3'b000, 8'h00, 8'h11, 1, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 3'b000, 8'h00, 8'h10, 1, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 3'b000, 8'h00, 8'h11, 1, 1)); // 25 underflow+incr
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 8'h00, 8'h00, 0, 0)); // sticky cleared
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3'b000, 8'h55, 8'h55, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 3'b000, 8'h22, 8'h22, 0, 0)); // top=55
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 3'b000, 8'h00, 8'h55, 0, 0)); // swap
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 3'b000, 8'h00, 8'h22, 0, 0)); // 30 top was 22
      vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 3'b000, 8'h00, 8'h23, 0, 1)); // depth was 1
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 8'h00, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 3'b000, 8'h00, 8'h00, 0, 1)); // swap on empty = push
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 3'b000, 8'h00, 8'h01, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 3'b000, 8'h00, 8'h00, 0, 1)); // 35 pop pushed 0
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 8'h00, 8'h00, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3'b001, 8'h33, 8'h00, 0, 0)); // Z cleared by reset
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3'b110, 8'h33, 8'h33, 0, 0)); // !N&!Z
      vecs.push_back(mk(1, 1, 1, 1, 1, 0, 1, 1, 3'b000, 8'hAA, 8'h00, 0, 0)); // reset overrides
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3'b001, 8'hAA, 8'h00, 0, 0)); // 40 flags not latched

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

      // Bus enable is combinational; o_bus holds the registered PC.
      apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 3'b000, 8'h55, 8'h55, 0, 0), 100);
      @(negedge clk);
      ld = 0; pcoe = 1;
      #1;
      check("busEn_on", 101, W'(bus_en), 8'h01);
      check("bus_drive", 101, bus_o, 8'h55);
      pcoe = 0;
      #1;
      check("busEn_off", 102, W'(bus_en), 8'h00);

      if (sb.size() != 0) begin
         checks++; fails++;
         $display("FAIL scoreboard leftover %0d entries", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
